path_controller: RTL and testbench

Top-level sequencer for the shortest-path engine. It accepts a search request (source, destination, obstacle list), clears the node-status memory, writes the obstacles, and launches the path-finding core. It then walks the predecessor memory from destination back to source and streams the resulting path out. It sits between the external request interface and the path core/memories, and owns all of their control signals.

---
 rtl/path_ctrl_pkg.sv | 24 ++
 rtl/path_controller_if.sv | 43 ++++
 rtl/path_readback.sv | 90 +++++++++
 rtl/path_controller.sv | 156 +++++++++++++++
 tb/tb_path_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/path_ctrl_pkg.sv
// Shared encodings for the path controller: FSM states, readback phases and node status codes.
package path_ctrl_pkg;

   localparam int unsigned STATUS_W = 2;

   localparam logic [STATUS_W-1:0] NODE_FREE = 2'b00;
   localparam logic [STATUS_W-1:0] NODE_OBST = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RECEIVE_DATA,
      ST_PATH,
      ST_SEND_DATA
   } state_t;

   typedef enum logic [1:0] {
      RB_IDLE,
      RB_RD,
      RB_WT,
      RB_EMIT
   } rb_phase_t;

endpackage

// File: rtl/path_controller_if.sv
// Request, obstacle, memory, core and path-stream signals between the controller and its environment.
interface path_controller_if #(parameter int unsigned NODE_WIDTH = 8);

   logic                                start;
   logic [NODE_WIDTH-1:0]               fonte;
   logic [NODE_WIDTH-1:0]               destino;
   logic [NODE_WIDTH-1:0]               obst_count;
   logic                                obst_valid;
   logic [NODE_WIDTH-1:0]               obst_data;
   logic                                obst_ready;
   logic                                mem_we;
   logic [NODE_WIDTH-1:0]               mem_addr;
   logic [path_ctrl_pkg::STATUS_W-1:0]  mem_wdata;
   logic                                core_start;
   logic [NODE_WIDTH-1:0]               core_src;
   logic [NODE_WIDTH-1:0]               core_dst;
   logic                                core_done;
   logic                                core_found;
   logic [NODE_WIDTH-1:0]               pred_addr;
   logic [NODE_WIDTH-1:0]               pred_rdata;
   logic                                path_valid;
   logic [NODE_WIDTH-1:0]               path_node;
   logic                                path_last;
   logic                                path_ready;
   logic                                busy;
   logic                                done;
   logic                                error;

   modport master (
      output start, fonte, destino, obst_count, obst_valid, obst_data,
             core_done, core_found, pred_rdata, path_ready,
      input  obst_ready, mem_we, mem_addr, mem_wdata, core_start, core_src, core_dst,
             pred_addr, path_valid, path_node, path_last, busy, done, error
   );

   modport slave (
      input  start, fonte, destino, obst_count, obst_valid, obst_data,
             core_done, core_found, pred_rdata, path_ready,
      output obst_ready, mem_we, mem_addr, mem_wdata, core_start, core_src, core_dst,
             pred_addr, path_valid, path_node, path_last, busy, done, error
   );

endinterface

// File: rtl/path_readback.sv
// Walks the predecessor memory from destination back to source, streaming one node per RD/WT/EMIT pass.
module path_readback
   import path_ctrl_pkg::*;
#(
   parameter int unsigned NODE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NODE_WIDTH-1:0] fonte,
   input  logic [NODE_WIDTH-1:0] destino,
   input  logic [NODE_WIDTH-1:0] pred_rdata,
   input  logic                  path_ready,
   output logic [NODE_WIDTH-1:0] pred_addr,
   output logic                  path_valid,
   output logic [NODE_WIDTH-1:0] path_node,
   output logic                  path_last,
   output logic                  fin_c,
   output logic                  fault_c
);

   localparam int unsigned NW = NODE_WIDTH;
   // Last step index whose successor would be the 2^NW-th node.
   localparam logic [NW-1:0] GUARD_STEP = {{(NW-1){1'b1}}, 1'b0};

   rb_phase_t     phase;
   logic [NW-1:0] cur;
   logic [NW-1:0] nxt;
   logic [NW-1:0] step;
   logic          hs_c;

   assign hs_c    = (phase == RB_EMIT) && path_ready;
   assign fin_c   = hs_c && path_last;
   assign fault_c = hs_c && !path_last && (step == GUARD_STEP) && (nxt != fonte);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= RB_IDLE;
         cur        <= '0;
         nxt        <= '0;
         step       <= '0;
         pred_addr  <= '0;
         path_valid <= 1'b0;
         path_node  <= '0;
         path_last  <= 1'b0;
      end else begin
         case (phase)
            RB_IDLE: begin
               if (start) begin
                  cur       <= destino;
                  step      <= '0;
                  pred_addr <= destino;
                  if (destino == fonte) begin
                     path_valid <= 1'b1;
                     path_node  <= destino;
                     path_last  <= 1'b1;
                     phase      <= RB_EMIT;
                  end else begin
                     phase <= RB_RD;
                  end
               end
            end
            RB_RD: phase <= RB_WT;
            RB_WT: begin
               nxt        <= pred_rdata;
               path_valid <= 1'b1;
               path_node  <= cur;
               path_last  <= (cur == fonte);
               phase      <= RB_EMIT;
            end
            RB_EMIT: begin
               if (path_ready) begin
                  path_valid <= 1'b0;
                  path_last  <= 1'b0;
                  if (path_last || fault_c) begin
                     phase <= RB_IDLE;
                  end else begin
                     cur       <= nxt;
                     step      <= step + NW'(1);
                     pred_addr <= nxt;
                     phase     <= RB_RD;
                  end
               end
            end
            default: phase <= RB_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/path_controller.sv
// Request sequencer: clears node status, loads obstacles, launches the core and streams the found path.
module path_controller
   import path_ctrl_pkg::*;
#(
   parameter int unsigned NODE_WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   path_controller_if.slave bus
);

   localparam int unsigned NW = NODE_WIDTH;
   localparam logic [NW-1:0] LAST_ADDR = '1;

   state_t              state;
   logic [NW-1:0]       fonte_q;
   logic [NW-1:0]       destino_q;
   logic [NW-1:0]       obst_cnt_q;
   logic [NW-1:0]       beat_cnt;
   logic                launched;
   logic                obst_ready_q;
   logic                mem_we_q;
   logic [NW-1:0]       mem_addr_q;
   logic [STATUS_W-1:0] mem_wdata_q;
   logic                core_start_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;
   logic                rb_start;
   logic                rb_fin_c;
   logic                rb_fault_c;

   assign bus.obst_ready = obst_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.core_start = core_start_q;
   assign bus.core_src   = fonte_q;
   assign bus.core_dst   = destino_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         fonte_q      <= '0;
         destino_q    <= '0;
         obst_cnt_q   <= '0;
         beat_cnt     <= '0;
         launched     <= 1'b0;
         obst_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= NODE_FREE;
         core_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         rb_start     <= 1'b0;
      end else begin
         mem_we_q     <= 1'b0;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         rb_start     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  fonte_q     <= bus.fonte;
                  destino_q   <= bus.destino;
                  obst_cnt_q  <= bus.obst_count;
                  error_q     <= 1'b0;
                  busy_q      <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= NODE_FREE;
                  state       <= ST_INIT;
               end
            end
            ST_INIT: begin
               if (mem_addr_q == LAST_ADDR) begin
                  beat_cnt <= '0;
                  if (obst_cnt_q != '0) begin
                     obst_ready_q <= 1'b1;
                     state        <= ST_RECEIVE_DATA;
                  end else begin
                     core_start_q <= 1'b1;
                     launched     <= 1'b1;
                     state        <= ST_PATH;
                  end
               end else begin
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= mem_addr_q + NW'(1);
               end
            end
            ST_RECEIVE_DATA: begin
               // Endpoints stay free even if listed as obstacles.
               if (bus.obst_valid && obst_ready_q) begin
                  mem_we_q    <= (bus.obst_data != fonte_q) && (bus.obst_data != destino_q);
                  mem_addr_q  <= bus.obst_data;
                  mem_wdata_q <= NODE_OBST;
                  beat_cnt    <= beat_cnt + NW'(1);
                  if ((beat_cnt + NW'(1)) == obst_cnt_q) begin
                     obst_ready_q <= 1'b0;
                     launched     <= 1'b0;
                     state        <= ST_PATH;
                  end
               end
            end
            ST_PATH: begin
               // Launch waits one cycle after the final obstacle so its write lands first.
               if (!launched) begin
                  core_start_q <= 1'b1;
                  launched     <= 1'b1;
               end else if (bus.core_done) begin
                  if (bus.core_found) begin
                     rb_start <= 1'b1;
                     state    <= ST_SEND_DATA;
                  end else begin
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_SEND_DATA: begin
               if (rb_fin_c || rb_fault_c) begin
                  error_q <= rb_fault_c;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   path_readback #(.NODE_WIDTH(NW)) u_readback (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (rb_start),
      .fonte      (fonte_q),
      .destino    (destino_q),
      .pred_rdata (bus.pred_rdata),
      .path_ready (bus.path_ready),
      .pred_addr  (bus.pred_addr),
      .path_valid (bus.path_valid),
      .path_node  (bus.path_node),
      .path_last  (bus.path_last),
      .fin_c      (rb_fin_c),
      .fault_c    (rb_fault_c)
   );

endmodule

// File: tb/tb_path_controller.sv
// Randomised bench for path_controller against a request-level reference model.
module tb_path_controller;
   import path_ctrl_pkg::*;

   localparam int unsigned NW = 4;
   localparam int NN = 1 << NW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   path_controller_if #(.NODE_WIDTH(NW)) bus ();
   path_controller #(.NODE_WIDTH(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference state
   logic [NW-1:0] pred_mem [NN];
   int  model_nodes[$];
   bit  model_err;
   int  exp_wr_addr[$], exp_wr_data[$], exp_path[$], exp_last[$];
   bit  exp_err, exp_found, req_active, cfg_found;
   int  exp_src, exp_dst, req_obst, beats_seen, start_cyc, core_expect_cyc;
   int  core_starts, core_done_cyc, last_hs_cyc, done_seen, beats_emitted;
   int  obst_writes, n_writes, core_delay;

   // Path from destination back to source; more than 2^NW-1 steps means a loop.
   task automatic model_path(input int src, input int dst);
      int cur;
      cur = dst;
      model_nodes.delete();
      model_err = 1'b0;
      for (int step = 0; step < NN; step++) begin
         if (step == NN - 1 && cur != src) begin
            model_err = 1'b1;
            break;
         end
         model_nodes.push_back(cur);
         if (cur == src) break;
         cur = int'(pred_mem[cur]);
      end
   endtask

   // Single compare process
   int  m_a, m_d;
   logic prev_valid, prev_ready, prev_last;
   logic [NW-1:0] prev_node;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_we) begin
            n_writes++;
            check("write_expected", 32'(exp_wr_addr.size() != 0), 1);
            if (exp_wr_addr.size() != 0) begin
               m_a = exp_wr_addr.pop_front();
               m_d = exp_wr_data.pop_front();
               check("mem_addr", 32'(bus.mem_addr), m_a);
               check("mem_wdata", 32'(bus.mem_wdata), m_d);
               if (m_d == 1) obst_writes++;
               if (m_d == 0 && m_a == NN - 1) begin
                  check("init_length", cyc - start_cyc, NN);
                  if (req_obst == 0) core_expect_cyc = cyc + 1;
               end
            end
         end
         if (bus.obst_valid && bus.obst_ready) begin
            beats_seen++;
            if (beats_seen == req_obst) core_expect_cyc = cyc + 2;
         end
         if (bus.core_start) begin
            core_starts++;
            check("core_start_cycle", cyc, core_expect_cyc);
            check("core_src", 32'(bus.core_src), exp_src);
            check("core_dst", 32'(bus.core_dst), exp_dst);
         end
         if (bus.core_done) core_done_cyc = cyc;
         if (prev_valid && !prev_ready) begin
            check("stall_valid", 32'(bus.path_valid), 1);
            check("stall_node", 32'(bus.path_node), 32'(prev_node));
            check("stall_last", 32'(bus.path_last), 32'(prev_last));
         end
         if (bus.path_valid && bus.path_ready) begin
            check("path_allowed", 32'(exp_found && req_active), 1);
            check("path_beat_expected", 32'(exp_path.size() != 0), 1);
            if (exp_path.size() != 0) begin
               m_a = exp_path.pop_front();
               m_d = exp_last.pop_front();
               check("path_node", 32'(bus.path_node), m_a);
               check("path_last", 32'(bus.path_last), m_d);
            end
            if (last_hs_cyc >= 0) check("beat_spacing", 32'(cyc - last_hs_cyc >= 3), 1);
            last_hs_cyc = cyc;
            beats_emitted++;
         end
         if (bus.done) begin
            done_seen++;
            check("done_expected", 32'(req_active), 1);
            check("done_error", 32'(bus.error), 32'(exp_err));
            check("busy_at_done", 32'(bus.busy), 0);
            check("path_drained", exp_path.size(), 0);
            if (exp_found) check("done_after_last_beat", cyc, last_hs_cyc + 1);
            else           check("done_after_core", cyc, core_done_cyc + 1);
            req_active = 1'b0;
         end
      end
      prev_valid = bus.path_valid;
      prev_ready = bus.path_ready;
      prev_node  = bus.path_node;
      prev_last  = bus.path_last;
   end

   // Predecessor memory: one-cycle read latency
   initial begin
      logic [NW-1:0] a;
      forever begin
         @(negedge clk);
         a = bus.pred_addr;
         @(posedge clk);
         #1 bus.pred_rdata = pred_mem[a];
      end
   end

   // Path core responder
   initial begin
      forever begin
         @(negedge clk);
         if (bus.core_start) begin
            repeat (core_delay) @(posedge clk);
            @(posedge clk);
            #1;
            bus.core_done  = 1'b1;
            bus.core_found = cfg_found;
            @(posedge clk);
            #1;
            bus.core_done  = 1'b0;
            bus.core_found = 1'b0;
         end
      end
   end

   // Randomly toggling downstream ready
   initial begin
      forever begin
         @(posedge clk);
         #1 bus.path_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic setup_expect(input int src, input int dst, input int obs[$], input bit found);
      model_path(src, dst);
      exp_wr_addr.delete(); exp_wr_data.delete(); exp_path.delete(); exp_last.delete();
      for (int a = 0; a < NN; a++) begin
         exp_wr_addr.push_back(a);
         exp_wr_data.push_back(0);
      end
      foreach (obs[i]) if (obs[i] != src && obs[i] != dst) begin
         exp_wr_addr.push_back(obs[i]);
         exp_wr_data.push_back(1);
      end
      if (found) foreach (model_nodes[i]) begin
         exp_path.push_back(model_nodes[i]);
         exp_last.push_back(int'(model_nodes[i] == src));
      end
      exp_err = found ? model_err : 1'b1;
      exp_found = found;
      cfg_found = found;
      exp_src = src;
      exp_dst = dst;
      req_obst = obs.size();
      beats_seen = 0;
      core_expect_cyc = -1;
      core_starts = 0;
      last_hs_cyc = -1;
      beats_emitted = 0;
      obst_writes = 0;
      req_active = 1'b1;
   endtask

   task automatic run_req(input int src, input int dst, input int obs[$], input bit found, input bit poke);
      int d0, t;
      bit hs;
      setup_expect(src, dst, obs, found);
      core_delay = $urandom_range(0, 4);
      d0 = done_seen;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b1;
      bus.fonte = NW'(src);
      bus.destino = NW'(dst);
      bus.obst_count = NW'(obs.size());
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.fonte = NW'($urandom);
      bus.destino = NW'($urandom);
      bus.obst_count = NW'($urandom);
      @(negedge clk);
      check("busy_cycle1", 32'(bus.busy), 1);
      check("error_cleared", 32'(bus.error), 0);
      check("first_write_cycle1", 32'(bus.mem_we), 1);
      @(posedge clk);
      #1;
      if (poke) begin
         bus.start = 1'b1;
         bus.fonte = NW'($urandom);
         bus.destino = NW'($urandom);
         bus.obst_count = NW'($urandom);
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      foreach (obs[i]) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         bus.obst_valid = 1'b1;
         bus.obst_data = NW'(obs[i]);
         t = 0;
         do begin
            @(negedge clk);
            hs = bus.obst_ready;
            @(posedge clk);
            #1;
            t++;
         end while (!hs && t < 200);
         check("obst_accepted", 32'(hs), 1);
         bus.obst_valid = 1'b0;
         bus.obst_data = NW'($urandom);
      end
      if (obs.size() != 0) begin
         @(negedge clk);
         check("obst_ready_drop", 32'(bus.obst_ready), 0);
      end
      t = 0;
      while (done_seen == d0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check("one_done", done_seen - d0, 1);
      check("one_core_start", core_starts, 1);
      check("writes_drained", exp_wr_addr.size(), 0);
      repeat (2) @(negedge clk);
      check("error_held", 32'(bus.error), 32'(exp_err));
      check("busy_idle", 32'(bus.busy), 0);
   endtask

   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      int obs[$];
      int wr0;
      bus.start = 1'b0; bus.fonte = '0; bus.destino = '0; bus.obst_count = '0;
      bus.obst_valid = 1'b0; bus.obst_data = '0; bus.core_done = 1'b0; bus.core_found = 1'b0;
      bus.pred_rdata = '0; bus.path_ready = 1'b0;
      for (int i = 0; i < NN; i++) pred_mem[i] = '0;
      core_delay = 0; cfg_found = 1'b0; req_active = 1'b0; done_seen = 0; n_writes = 0;
      last_hs_cyc = -1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_error", 32'(bus.error), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      check("rst_core_start", 32'(bus.core_start), 0);
      check("rst_path_valid", 32'(bus.path_valid), 0);
      check("rst_core_src", 32'(bus.core_src), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of INIT
      obs.delete();
      setup_expect(0, 3, obs, 1'b0);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b1; bus.fonte = 4'd1; bus.destino = 4'd2; bus.obst_count = 4'd0;
      exp_src = 1; exp_dst = 2;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_mem_we", 32'(bus.mem_we), 0);
      check("abort_mem_addr", 32'(bus.mem_addr), 0);
      check("abort_obst_ready", 32'(bus.obst_ready), 0);
      check("abort_done", 32'(bus.done), 0);
      exp_wr_addr.delete(); exp_wr_data.delete();
      req_active = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr0 = n_writes;
      repeat (20) @(negedge clk);
      check("post_reset_writes", n_writes - wr0, 0);
      check("post_reset_busy", 32'(bus.busy), 0);

      // Chain 3->2->1->0, no obstacles
      pred_mem[3] = 4'd2; pred_mem[2] = 4'd1; pred_mem[1] = 4'd0;
      model_path(0, 3);
      check("model_chain_len", model_nodes.size(), 4);
      check("model_chain_tail", model_nodes[3], 0);
      obs.delete();
      run_req(0, 3, obs, 1'b1, 1'b0);
      check("chain_beats", beats_emitted, 4);

      // Obstacles 5, 6, 0 with no path
      obs = '{5, 6, 0};
      run_req(0, 3, obs, 1'b0, 1'b0);
      check("obst_writes", obst_writes, 2);
      check("nopath_beats", beats_emitted, 0);

      // Predecessor loop 3<->2
      pred_mem[2] = 4'd3;
      model_path(0, 3);
      check("model_loop_len", model_nodes.size(), 15);
      check("model_loop_err", 32'(model_err), 1);
      obs.delete();
      run_req(0, 3, obs, 1'b1, 1'b0);
      check("loop_beats", beats_emitted, 15);

      // Source equals destination, with start poked while busy
      obs = '{7, 9};
      run_req(7, 7, obs, 1'b1, 1'b1);
      check("single_beats", beats_emitted, 1);

      // Random requests
      for (int r = 0; r < 8; r++) begin
         int src, dst, found;
         for (int i = 0; i < NN; i++) pred_mem[i] = NW'($urandom);
         src = $urandom_range(0, NN - 1);
         dst = $urandom_range(0, NN - 1);
         found = ($urandom_range(0, 3) != 0);
         obs.delete();
         repeat ($urandom_range(0, 5)) obs.push_back($urandom_range(0, NN - 1));
         run_req(src, dst, obs, found[0], r[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
